// File: rtl/reg_dec_pkg.sv
// Shared definitions for the registered decoder/sequencer.
//   state_e   : sequencer FSM states (IDLE, SWEEP, DONE)
//   SEL_W_DEF : default select index width
//   OUT_N_DEF : default number of decoded outputs
package reg_dec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned SEL_W_DEF = 3;
    localparam int unsigned OUT_N_DEF = 8;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder, shared by the direct and sweep paths.
//   idx    : binary index
//   valid  : when low the output is all zeros
//   onehot : bit idx set when valid and idx < OUT_N, otherwise all zeros
module onehot_dec #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned OUT_N = 8
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             valid,
    output logic [OUT_N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < OUT_N; i++) begin
            if (valid && (idx == SEL_W'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_dec_seq.sv
// Registered one-hot decoder with an automatic output sweep sequencer.
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   en          : direct-decode enable (IDLE only)
//   sel         : direct-decode index
//   sweep_start : walk all outputs in order (IDLE only, wins over en)
//   Y           : registered decoded outputs, polarity set by ACT_HIGH
//   sweep_busy  : high while the walk is presenting outputs
//   sweep_done  : one-cycle pulse after the last output of a walk
//   oor_err     : one-cycle pulse for a direct decode with sel >= OUT_N
module reg_dec_seq
    import reg_dec_pkg::*;
#(
    parameter int unsigned SEL_W    = SEL_W_DEF,
    parameter int unsigned OUT_N    = OUT_N_DEF,
    parameter int unsigned ACT_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             sweep_start,
    output logic [OUT_N-1:0] Y,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             oor_err
);

    if (SEL_W < 1 || SEL_W > 6 || OUT_N < 2 || OUT_N > (1 << SEL_W)) begin : g_param_check
        $error("reg_dec_seq: illegal SEL_W/OUT_N combination");
    end

    localparam logic [OUT_N-1:0] Y_IDLE   = {OUT_N{ACT_HIGH == 0}};
    localparam logic [SEL_W:0]   OUT_N_W  = OUT_N[SEL_W:0];
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [OUT_N-1:0] y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             oor_q, oor_d;

    logic [SEL_W-1:0] dec_idx;
    logic             dec_valid;
    logic [OUT_N-1:0] dec_y;
    logic             sel_in_range;

    // Extra MSB keeps the compare unsigned and correct when OUT_N == 2**SEL_W.
    assign sel_in_range = ({1'b0, sel} < OUT_N_W);

    onehot_dec #(
        .SEL_W (SEL_W),
        .OUT_N (OUT_N)
    ) u_dec (
        .idx    (dec_idx),
        .valid  (dec_valid),
        .onehot (dec_y)
    );

    // The decoder always sees the index that Y must show in the next cycle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        oor_d     = 1'b0;
        dec_idx   = idx_q + SEL_W'(1);
        dec_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    state_d   = SWEEP;
                    idx_d     = '0;
                    dec_idx   = '0;
                    dec_valid = 1'b1;
                    busy_d    = 1'b1;
                end else if (en) begin
                    dec_idx   = sel;
                    dec_valid = sel_in_range;
                    oor_d     = !sel_in_range;
                end
            end
            SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d     = idx_q + SEL_W'(1);
                    dec_valid = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Polarity is applied here so the output register holds the pin value.
    assign y_d = (ACT_HIGH != 0) ? dec_y : ~dec_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            y_q     <= Y_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oor_q   <= oor_d;
        end
    end

    assign Y          = y_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign oor_err    = oor_q;

endmodule
